// File: rtl/synaptic_input_driver_pkg.sv
// synaptic_input_driver_pkg: shared FSM state type and saturating fixed-point helpers
package synaptic_input_driver_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_APPLY} state_t;

    localparam int SW = 64;

    typedef struct packed {
        logic signed [SW-1:0] val;
        logic                 clamped;
    } sat_t;

    function automatic logic signed [SW-1:0] sat_hi(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SW-1:0] sat_lo(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    function automatic sat_t sat_add(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b, input int n);
        logic signed [SW-1:0] s;
        sat_t r;
        s = a + b;
        r.clamped = (s > sat_hi(n)) || (s < sat_lo(n));
        r.val = (s > sat_hi(n)) ? sat_hi(n) : (s < sat_lo(n)) ? sat_lo(n) : s;
        return r;
    endfunction

endpackage

// File: rtl/synaptic_input_driver_spike_edge_counter.sv
// synaptic_input_driver_spike_edge_counter: rising-edge detector feeding a 3-bit saturating spike counter
module synaptic_input_driver_spike_edge_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic       clr,
    output logic [2:0] count
);

    logic       prev_q, prev_d, rise;
    logic [2:0] count_q, count_d;

    // clr reloads with this cycle's edge so a spike coinciding with the clear is kept
    always_comb begin
        rise    = spike_in && !prev_q;
        prev_d  = spike_in;
        count_d = clr ? {2'b00, rise} : (rise && count_q != 3'd7) ? count_q + 3'd1 : count_q;
    end

    // edge-detect and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            count_q <= 3'd0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/synaptic_input_driver.sv
// synaptic_input_driver: periodic decaying synaptic current with a one-cycle apply strobe for a neuron core
module synaptic_input_driver
    import synaptic_input_driver_pkg::*;
#(
    parameter int N     = 18,
    parameter int Q     = 10,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                spike_in,
    input  logic signed [N-1:0] weight,
    input  logic signed [N-1:0] i_bias,
    input  logic [3:0]          decay_shift,
    input  logic [CNT_W-1:0]    period,
    output logic signed [N-1:0] i_out,
    output logic                apply,
    output logic [2:0]          pending,
    output logic                sat
);

    localparam int W = N + 4;

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("Q must lie in [0, N)");
    end

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, reload;
    logic signed [N-1:0]  i_syn_q, i_syn_d, i_out_q, i_out_d;
    logic                 apply_q, apply_d, sat_q, sat_d, clr;
    logic signed [W-1:0]  syn_w, dec_w, prod_w;
    logic [2:0]           pend;
    sat_t                 upd, drv;

    synaptic_input_driver_spike_edge_counter u_spike_edge_counter (
        .clk      (clk),
        .rst      (rst),
        .spike_in (spike_in),
        .clr      (clr),
        .count    (pend)
    );

    // decayed current plus weighted spikes, then bias, both clamped to the N-bit range
    always_comb begin
        syn_w  = W'(i_syn_q);
        dec_w  = syn_w - (syn_w >>> decay_shift);
        prod_w = W'(weight) * $signed({{(W-3){1'b0}}, pend});
        upd    = sat_add(SW'(dec_w), SW'(prod_w), N);
        drv    = sat_add(SW'(i_bias), SW'($signed(upd.val[N-1:0])), N);
        reload = (period == '0) ? '0 : period - CNT_W'(1);
    end

    // step scheduler: wait max(period,1) cycles, update once, strobe apply once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_syn_d = i_syn_q;
        i_out_d = i_out_q;
        apply_d = 1'b0;
        sat_d   = sat_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = enable ? S_WAIT : S_IDLE;
                cnt_d   = reload;
            end
            S_WAIT: begin
                state_d = !enable ? S_IDLE : (cnt_q == '0) ? S_UPDATE : S_WAIT;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
            end
            S_UPDATE: begin
                clr     = 1'b1;
                i_syn_d = upd.val[N-1:0];
                i_out_d = drv.val[N-1:0];
                apply_d = 1'b1;
                sat_d   = sat_q | upd.clamped | drv.clamped;
                state_d = S_APPLY;
            end
            default: begin
                state_d = enable ? S_WAIT : S_IDLE;
                cnt_d   = reload;
            end
        endcase
    end

    // state and registered outputs; reset overrides any step in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            i_syn_q <= '0;
            i_out_q <= '0;
            apply_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_syn_q <= i_syn_d;
            i_out_q <= i_out_d;
            apply_q <= apply_d;
            sat_q   <= sat_d;
        end
    end

    assign i_out   = i_out_q;
    assign apply   = apply_q;
    assign pending = pend;
    assign sat     = sat_q;

endmodule

// File: tb/tb_synaptic_input_driver.sv
// tb_synaptic_input_driver: directed vector table, hand sequences and random run against a reference model
module tb_synaptic_input_driver;

    localparam longint HI = 131071;
    localparam longint LO = -131072;

    logic               clk, rst, enable, spike_in, apply, sat;
    logic signed [17:0] weight, i_bias, i_out;
    logic [3:0]         decay_shift;
    logic [15:0]        period;
    logic [2:0]         pending;

    int checks = 0, failures = 0;
    bit cmp_model = 0;

    bit     m_prev, m_apply, m_run, m_sat;
    int     m_r, m_pend;
    longint m_syn, m_out;

    typedef struct {
        int period; int weight; int bias; int ds; int edges;
        int exp_pend; int exp1; int exp2; int exp_sat;
    } vec_t;
    vec_t vecs[7];

    synaptic_input_driver #(.N(18), .Q(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
        .weight(weight), .i_bias(i_bias), .decay_shift(decay_shift), .period(period),
        .i_out(i_out), .apply(apply), .pending(pending), .sat(sat)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > HI) begin m_sat = 1; return HI; end
        if (v < LO) begin m_sat = 1; return LO; end
        return v;
    endfunction

    task automatic model_step();
        bit e;
        int p;
        longint s;
        e = spike_in && !m_prev;
        p = (period == 0) ? 1 : int'(period);
        if (rst) begin
            m_prev = 0; m_apply = 0; m_run = 0; m_sat = 0;
            m_r = 0; m_pend = 0; m_syn = 0; m_out = 0;
        end else begin
            m_prev = spike_in;
            if (m_run && !m_apply && m_r == 1) begin
                s = m_syn - (m_syn >>> decay_shift) + longint'(weight) * m_pend;
                m_syn = clampv(s);
                m_out = clampv(longint'(i_bias) + m_syn);
                m_pend = int'(e);
                m_apply = 1;
                m_r = 0;
            end else begin
                if (e && m_pend < 7) m_pend++;
                if (m_apply) begin
                    m_apply = 0; m_run = enable; m_r = p + 1;
                end else if (m_run) begin
                    m_r--;
                    if (!enable) m_run = 0;
                end else if (enable) begin
                    m_run = 1; m_r = p + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (cmp_model) begin
            chk("rnd_apply", apply, m_apply);
            chk("rnd_i_out", i_out, m_out);
            chk("rnd_pending", pending, m_pend);
            chk("rnd_sat", sat, m_sat);
        end
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

    task automatic wait_apply(output int n);
        n = 0;
        do begin cyc(); n++; end while (apply !== 1'b1 && n < 200);
        if (apply !== 1'b1) chk("apply_timeout", 0, 1);
    endtask

    initial begin
        int n, cnt;
        vecs[0] = '{4,      0,  5120, 0, 0, 0,   5120,   5120, 0};
        vecs[1] = '{20,  2048,     0, 1, 1, 1,   2048,   1024, 0};
        vecs[2] = '{20,  2048,     0, 1, 9, 7,  14336,   7168, 0};
        vecs[3] = '{20, 131071,    0, 1, 3, 3, 131071,  65536, 1};
        vecs[4] = '{20, -3000,   100, 0, 2, 2,  -5900,    100, 0};
        vecs[5] = '{20, -131072,  -5, 1, 2, 2, -131072, -65541, 1};
        vecs[6] = '{0,      0,   -77, 3, 0, 0,    -77,    -77, 0};
        rst = 1; enable = 1; spike_in = 1; weight = 18'sd2048; i_bias = 18'sd5120;
        decay_shift = 4'd2; period = 16'd3;
        cyc(); cyc();
        chk("reset_i_out", i_out, 0);
        chk("reset_apply", apply, 0);
        chk("reset_pending", pending, 0);
        chk("reset_sat", sat, 0);
        rst = 0; enable = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cyc(); cnt += int'(apply); end
        chk("no_apply_while_disabled", cnt, 0);
        enable = 1;
        wait_apply(n);
        chk("first_apply_latency", n, 5);

        foreach (vecs[k]) begin
            do_reset();
            period = 16'(vecs[k].period); weight = 18'(vecs[k].weight); i_bias = 18'(vecs[k].bias);
            decay_shift = 4'(vecs[k].ds); spike_in = 0; enable = 1;
            cyc();
            for (int j = 0; j < vecs[k].edges; j++) begin
                spike_in = 1; cyc(); spike_in = 0; cyc();
            end
            chk($sformatf("vec%0d_pending", k), pending, vecs[k].exp_pend);
            wait_apply(n);
            chk($sformatf("vec%0d_i_out1", k), i_out, vecs[k].exp1);
            wait_apply(n);
            chk($sformatf("vec%0d_interval", k), n, (vecs[k].period == 0 ? 1 : vecs[k].period) + 2);
            chk($sformatf("vec%0d_i_out2", k), i_out, vecs[k].exp2);
            chk($sformatf("vec%0d_sat", k), sat, vecs[k].exp_sat);
        end

        do_reset();
        enable = 0; spike_in = 1;
        for (int i = 0; i < 20; i++) cyc();
        chk("held_level_pending", pending, 1);
        spike_in = 0;

        do_reset();
        period = 16'd20; weight = 18'sd1000; i_bias = 18'sd0; enable = 1;
        for (int i = 0; i < 5; i++) cyc();
        enable = 0; cnt = 0;
        for (int i = 0; i < 40; i++) begin cyc(); cnt += int'(apply); end
        chk("disable_in_wait_applies", cnt, 0);

        do_reset();
        period = 16'd3; weight = 18'sd131071; enable = 1;
        spike_in = 1; cyc(); spike_in = 0; cyc(); spike_in = 1; cyc(); spike_in = 0;
        wait_apply(n);
        chk("pre_reset_sat", sat, 1);
        rst = 1; enable = 0; cyc(); rst = 0;
        chk("mid_apply_reset_apply", apply, 0);
        chk("mid_apply_reset_i_out", i_out, 0);
        chk("mid_apply_reset_sat", sat, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin cyc(); cnt += int'(apply); end
        chk("post_reset_applies", cnt, 0);

        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            cmp_model = 1;
            period = 16'($urandom_range(0, 5));
            weight = (seg % 3 == 0) ? 18'($urandom) : 18'($urandom_range(0, 8000)) - 18'sd4000;
            i_bias = (seg % 2 == 0) ? 18'($urandom) : 18'($urandom_range(0, 2000)) - 18'sd1000;
            decay_shift = 4'($urandom_range(0, 15));
            for (int i = 0; i < 120; i++) begin
                enable = ($urandom_range(0, 14) != 0);
                spike_in = ($urandom_range(0, 2) == 0);
                cyc();
            end
            cmp_model = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/synaptic_input_driver.md
SYNAPTIC_INPUT_DRIVER -- requirements
Module: synaptic_input_driver

Interface
REQ-001 Parameter N, default 18: fixed-point word width; two's complement signed.
REQ-002 Parameter Q, default 10: fractional bits, so 1.0 = 2^Q.
REQ-003 Parameter CNT_W, default 16: width of the step-period counter.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Clock and reset ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
REQ-006 Data and control ports:
- enable  input  1  run the step scheduler.
- spike_in  input  1  presynaptic spike level, held high for one or more cycles per spike.
- weight  input  N  signed synaptic weight per spike.
- i_bias  input  N  signed constant input current.
- decay_shift  input  4  decay per step, i_syn -= i_syn >>> decay_shift.
- period  input  CNT_W  wait cycles per step.
- i_out  output  N  signed current for the neuron core's i input.
- apply  output  1  one-cycle strobe for the neuron core's apply input.
- pending  output  3  spike edges accumulated in the current window.
- sat  output  1  sticky saturation flag.

Function
REQ-007 Spike detection: count a spike only on a rising edge (spike_in=1, previous sample 0); a held-high level counts once.
REQ-008 pending accumulation:
- increment pending by one on each edge;
- saturate pending at 7.
REQ-009 FSM states: IDLE, WAIT, UPDATE, APPLY.
REQ-010 IDLE transitions: go to WAIT when enable=1, loading the counter with max(period,1)-1.
REQ-011 WAIT:
- decrement the counter each cycle;
- when the counter equals 0, go to UPDATE;
- WAIT lasts max(period,1) cycles.
REQ-012 UPDATE (one cycle):
- i_syn <= sat(i_syn - (i_syn >>> decay_shift) + weight*pending), arithmetic shift;
- clear pending;
- go to APPLY.
REQ-013 UPDATE edge case: a spike edge arriving in the UPDATE cycle sets pending to 1 and is not lost.
REQ-014 APPLY (one cycle):
- apply=1 and i_out = sat(i_bias + i_syn), registered, valid in the same cycle;
- then WAIT with the counter reloaded, or IDLE if enable=0.
REQ-015 Strobe timing: apply pulses once every max(period,1)+2 cycles while enable stays high.
REQ-016 Deassertion of enable:
- from WAIT, enter IDLE next cycle;
- an UPDATE already in progress completes through APPLY.
REQ-017 Holding while disabled: i_out and i_syn hold while disabled; edges keep accumulating into pending.
REQ-018 decay_shift=0 yields full decay; i_syn becomes weight*pending only.
REQ-019 Arithmetic width and saturation:
- compute all sums and the weight*pending product at N+4 bits;
- clamp to [-2^(N-1), 2^(N-1)-1];
- any clamp sets sat=1.
REQ-020 apply is never high in two consecutive cycles.

Reset
REQ-021 On rst=1 at a clock edge, all of the following SHALL be 0: i_out, i_syn, apply, pending, sat, the counter and the edge-detect register; the state SHALL be IDLE.
REQ-022 Reset has priority over every other event, including reset mid-UPDATE or mid-APPLY; no apply pulse follows reset.

Structure
REQ-023 Shared fixed-point package:
- FSM state enum;
- saturating add helper and saturation limits as functions of N.
REQ-024 Sub-module: one spike_edge_counter (edge detect plus 3-bit saturating counter with a clear-with-load input); everything else stays in synaptic_input_driver.

Verification
All scenarios use N=18, Q=10.
REQ-025 Reset with all inputs nonzero -> every output 0, apply stays 0 until enable is asserted.
REQ-026 Constant current: i_bias=5120, weight=0, period=4, enable=1 -> apply every 6 cycles, i_out=5120 each pulse.
REQ-027 Single spike then decay: i_bias=0, weight=2048, decay_shift=1, one spike edge in the first window -> i_out 2048, 1024, 512, 256 on successive pulses.
REQ-028 Held level: spike_in held high for 20 cycles -> pending counts 1.
REQ-029 Pending saturation: 9 edges in one window -> pending=7 before UPDATE; i_out=14336 with weight=2048 and i_syn previously 0.
REQ-030 Positive saturation plus reset: weight=131071, 3 edges -> i_out=131071, sat=1 sticky; then rst -> sat=0.
